// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and control-bit indices for the memory stage
package mem_stage_pkg;
  localparam int XLEN = 64;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
  typedef struct packed {
    logic            valid;
    logic [4:0]      ctrl;
    logic [4:0]      rd;
    logic            zero;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] writeData;
    logic [XLEN-1:0] PCBranch;
  } exmem_t;
endpackage

// File: rtl/mem_stage_exmem_reg.sv
// exmem_reg: EX/MEM pipeline register with enable, flush and async reset
module exmem_reg
  import mem_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   flush,
  input  exmem_t d,
  output exmem_t q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (en) begin
      q <= d;
      q.valid <= d.valid & ~flush;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, branch resolve, req/ack data-memory FSM with timeout, writeback outputs
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  input  logic         valid_E,
  input  logic [4:0]   ctrl_E,
  input  logic [4:0]   rd_E,
  input  logic         flush_M,
  output logic         stall_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_ack,
  input  logic [N-1:0] dmem_rdata,
  output logic         valid_W,
  output logic         RegWrite_W,
  output logic         MemtoReg_W,
  output logic [4:0]   rd_W,
  output logic [N-1:0] aluResult_W,
  output logic [N-1:0] readData_W,
  output logic         err_M
);
  localparam int CW = $clog2(TIMEOUT);
  exmem_t d, m;
  mem_state_t state;
  logic [CW-1:0] cnt;
  logic [N-1:0] rdata_q;
  logic memop, busy, mis;
  assign d = '{valid: valid_E, ctrl: ctrl_E, rd: rd_E, zero: zero_E,
               aluResult: aluResult_E, writeData: writeData_E, PCBranch: PCBranch_E};
  exmem_reg u_exmem (.clk(clk), .reset(reset), .en(~stall_M), .flush(flush_M), .d(d), .q(m));
  assign memop = m.valid & (m.ctrl[CTRL_MEMREAD] | m.ctrl[CTRL_MEMWRITE]);
  assign busy  = state == BUSY;
  assign mis   = m.aluResult[2:0] != 3'd0;
  assign stall_M = busy | (state == IDLE & memop);
  // misaligned accesses never reach the bus: they skip BUSY and flag the error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_M   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (memop) begin
          state <= mis ? DONE : BUSY;
          if (mis) err_M <= 1'b1;
        end
        BUSY: if (dmem_ack) begin
          state <= DONE;
          if (!m.ctrl[CTRL_MEMWRITE]) rdata_q <= dmem_rdata;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state   <= DONE;
          err_M   <= 1'b1;
          rdata_q <= '0;
        end else cnt <= cnt + 1'b1;
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign PCSrc_M     = m.valid & m.ctrl[CTRL_BRANCH] & m.zero;
  assign PCBranch_M  = m.PCBranch;
  assign dmem_req    = busy;
  assign dmem_we     = busy & m.ctrl[CTRL_MEMWRITE];
  assign dmem_addr   = m.aluResult;
  assign dmem_wdata  = m.writeData;
  assign valid_W     = m.valid & ~stall_M;
  assign RegWrite_W  = valid_W & m.ctrl[CTRL_REGWRITE];
  assign MemtoReg_W  = m.ctrl[CTRL_MEMTOREG];
  assign rd_W        = m.rd;
  assign aluResult_W = m.aluResult;
  assign readData_W  = rdata_q;
endmodule
